// File: rtl/servo_seq_ctl_if.sv
// rtl/servo_seq_ctl_if.sv - angle load handshake between sequencer and PWM generator
interface servo_seq_ctl_if;
    logic [7:0] out_angle;
    logic       out_vld;
    logic       out_rdy;

    modport master (output out_angle, output out_vld, input out_rdy);
    modport slave  (input out_angle, input out_vld, output out_rdy);
endinterface

// File: rtl/servo_seq_ctl.sv
// rtl/servo_seq_ctl.sv - frame-synchronous, rate-limited servo angle sequencer
module servo_seq_ctl #(
    parameter int unsigned FRAME_CYCLES = 240000,
    parameter logic [7:0]  STEP         = 8'd2,
    parameter logic [7:0]  INIT_ANGLE   = 8'd90,
    parameter logic [7:0]  SWEEP_MIN    = 8'd0,
    parameter logic [7:0]  SWEEP_MAX    = 8'd180,
    parameter logic [7:0]  HOLD_FRAMES  = 8'd25
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [7:0]             man_angle,
    output logic                   frame_tick,
    output logic                   sweeping,
    output logic                   ovr,
    servo_seq_ctl_if.master        pwm
);
    localparam int FCW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_CYCLES - 1);

    typedef enum logic [2:0] {MANUAL, SWP_UP, HOLD_HI, SWP_DN, HOLD_LO} state_t;

    logic [FCW-1:0] fc_q, fc_d;
    logic [7:0]     cur_q, cur_d;
    logic [7:0]     hcnt_q, hcnt_d;
    state_t         state_q, state_d;
    logic           vld_q, vld_d;
    logic           ovr_q, ovr_d;
    logic           swp_q, swp_d;

    logic       pending;
    logic [7:0] man_clamped;
    logic [7:0] tgt;
    logic [7:0] diff;
    logic [7:0] hcnt_inc;

    assign frame_tick    = (fc_q == FC_LAST);
    assign pending       = vld_q & ~pwm.out_rdy;
    assign man_clamped   = (man_angle > 8'd180) ? 8'd180 : man_angle;
    assign hcnt_inc      = hcnt_q + 8'd1;
    assign pwm.out_angle = cur_q;
    assign pwm.out_vld   = vld_q;
    assign ovr           = ovr_q;
    assign sweeping      = swp_q;

    always_comb begin
        tgt = cur_q;
        case (state_q)
            MANUAL:  tgt = man_clamped;
            SWP_UP:  tgt = SWEEP_MAX;
            SWP_DN:  tgt = SWEEP_MIN;
            default: tgt = cur_q;
        endcase
    end

    always_comb begin
        fc_d    = frame_tick ? '0 : fc_q + FCW'(1);
        cur_d   = cur_q;
        hcnt_d  = hcnt_q;
        state_d = state_q;
        vld_d   = vld_q;
        ovr_d   = 1'b0;
        diff    = 8'd0;

        if (frame_tick && pending) begin
            // Generator has not taken the previous angle: freeze everything.
            ovr_d = 1'b1;
        end else if (frame_tick) begin
            vld_d = 1'b1;
            if (cur_q < tgt) begin
                diff  = tgt - cur_q;
                cur_d = cur_q + ((diff < STEP) ? diff : STEP);
            end else if (cur_q > tgt) begin
                diff  = cur_q - tgt;
                cur_d = cur_q - ((diff < STEP) ? diff : STEP);
            end

            if (state_q == MANUAL) begin
                if (mode) begin
                    state_d = (cur_d < SWEEP_MAX) ? SWP_UP : SWP_DN;
                    hcnt_d  = 8'd0;
                end
            end else if (!mode) begin
                state_d = MANUAL;
                hcnt_d  = 8'd0;
            end else begin
                case (state_q)
                    SWP_UP: if (cur_d == SWEEP_MAX) begin
                        state_d = HOLD_HI;
                        hcnt_d  = 8'd0;
                    end
                    SWP_DN: if (cur_d == SWEEP_MIN) begin
                        state_d = HOLD_LO;
                        hcnt_d  = 8'd0;
                    end
                    HOLD_HI, HOLD_LO: begin
                        if (hcnt_inc >= HOLD_FRAMES) begin
                            state_d = (state_q == HOLD_HI) ? SWP_DN : SWP_UP;
                            hcnt_d  = 8'd0;
                        end else begin
                            hcnt_d  = hcnt_inc;
                        end
                    end
                    default: state_d = MANUAL;
                endcase
            end
        end else if (vld_q && pwm.out_rdy) begin
            vld_d = 1'b0;
        end

        swp_d = (state_d != MANUAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_q    <= '0;
            cur_q   <= INIT_ANGLE;
            hcnt_q  <= 8'd0;
            state_q <= MANUAL;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            swp_q   <= 1'b0;
        end else begin
            fc_q    <= fc_d;
            cur_q   <= cur_d;
            hcnt_q  <= hcnt_d;
            state_q <= state_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            swp_q   <= swp_d;
        end
    end
endmodule

// File: tb/tb_servo_seq_ctl.sv
// tb/tb_servo_seq_ctl.sv - directed self-checking bench for servo_seq_ctl
module tb_servo_seq_ctl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [7:0] man_angle;
    logic       frame_tick;
    logic       sweeping;
    logic       ovr;
    int         total = 0;
    int         bad = 0;

    servo_seq_ctl_if pwm_if ();

    servo_seq_ctl #(
        .FRAME_CYCLES(16),
        .STEP        (8'd2),
        .INIT_ANGLE  (8'd90),
        .SWEEP_MIN   (8'd0),
        .SWEEP_MAX   (8'd180),
        .HOLD_FRAMES (8'd2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .man_angle (man_angle),
        .frame_tick(frame_tick),
        .sweeping  (sweeping),
        .ovr       (ovr),
        .pwm       (pwm_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the negedge just after the frame_tick edge.
    task automatic wait_frame();
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (frame_tick !== 1'b1) check("tick_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic expect_frame(input string tag, input int ang, input int swp);
        wait_frame();
        check({tag, "_vld"}, int'(pwm_if.out_vld), 1);
        check({tag, "_ang"}, int'(pwm_if.out_angle), ang);
        check({tag, "_swp"}, int'(sweeping), swp);
    endtask

    initial begin
        int n;
        int exp;
        int ovr_cnt;
        rst_n = 1'b0;
        mode = 1'b0;
        man_angle = 8'd90;
        pwm_if.out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_vld", int'(pwm_if.out_vld), 0);
        check("rst_ang", int'(pwm_if.out_angle), 90);
        check("rst_swp", int'(sweeping), 0);
        check("rst_ovr", int'(ovr), 0);
        check("rst_tick", int'(frame_tick), 0);

        rst_n = 1'b1;
        n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("first_tick_cycles", n, 15);
        check("vld_before_tick", int'(pwm_if.out_vld), 0);
        @(negedge clk);
        check("first_vld", int'(pwm_if.out_vld), 1);
        check("first_ang", int'(pwm_if.out_angle), 90);
        @(negedge clk);
        check("vld_fall", int'(pwm_if.out_vld), 0);
        expect_frame("hold90", 90, 0);

        man_angle = 8'd95;
        expect_frame("m95_a", 92, 0);
        expect_frame("m95_b", 94, 0);
        expect_frame("m95_c", 95, 0);
        expect_frame("m95_d", 95, 0);
        @(negedge clk);
        check("vld_pulse1", int'(pwm_if.out_vld), 0);

        man_angle = 8'd255;
        exp = 95;
        for (int i = 0; i < 45; i++) begin
            exp = (exp + 2 > 180) ? 180 : exp + 2;
            expect_frame("clamp", exp, 0);
        end
        check("clamp_final", int'(pwm_if.out_angle), 180);

        man_angle = 8'd176;
        expect_frame("m176_a", 178, 0);
        expect_frame("m176_b", 176, 0);
        mode = 1'b1;
        expect_frame("sw_enter", 176, 1);
        expect_frame("sw_up_a", 178, 1);
        expect_frame("sw_up_b", 180, 1);
        expect_frame("hold_hi_a", 180, 1);
        expect_frame("hold_hi_b", 180, 1);
        for (int a = 178; a >= 0; a -= 2) expect_frame("sw_dn", a, 1);
        expect_frame("hold_lo_a", 0, 1);
        expect_frame("hold_lo_b", 0, 1);
        for (int a = 2; a <= 180; a += 2) expect_frame("sw_up2", a, 1);
        expect_frame("hold_hi2_a", 180, 1);
        expect_frame("hold_hi2_b", 180, 1);
        for (int a = 178; a >= 102; a -= 2) expect_frame("sw_dn2", a, 1);

        mode = 1'b0;
        man_angle = 8'd120;
        expect_frame("to_man", 100, 0);
        expect_frame("man_a", 102, 0);
        expect_frame("man_b", 104, 0);

        pwm_if.out_rdy = 1'b0;
        ovr_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ovr === 1'b1) ovr_cnt++;
            check("stall_vld", int'(pwm_if.out_vld), 1);
            check("stall_ang", int'(pwm_if.out_angle), 104);
        end
        check("ovr_count", ovr_cnt, 2);
        pwm_if.out_rdy = 1'b1;
        @(negedge clk);
        check("stall_release_vld", int'(pwm_if.out_vld), 0);
        for (int a = 106; a <= 120; a += 2) expect_frame("resume", a, 0);

        man_angle = 8'd200;
        for (int a = 122; a <= 140; a += 2) expect_frame("to140", a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", int'(pwm_if.out_vld), 0);
        check("mid_rst_ang", int'(pwm_if.out_angle), 90);
        check("mid_rst_swp", int'(sweeping), 0);
        repeat (3) @(negedge clk);
        check("mid_rst_hold_ang", int'(pwm_if.out_angle), 90);
        rst_n = 1'b1;
        n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_fc_restart", n, 15);
        @(negedge clk);
        check("post_rst_vld", int'(pwm_if.out_vld), 1);
        check("post_rst_ang", int'(pwm_if.out_angle), 92);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
